// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: NOP encoding, fetch FSM states and default reset PC.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_IDLE      = 2'd0,
      FS_WAIT      = 2'd1,
      FS_WAIT_KILL = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Priority select of the redirect source: trap over branch over jump.
module fetch_redirect_sel (
   input  logic        flush_trap,
   input  logic [31:0] trap_target,
   input  logic        flush_branch,
   input  logic [31:0] branch_target,
   input  logic        flush_jal,
   input  logic [31:0] jal_target,
   output logic        redirect,
   output logic [31:0] target
);

   always_comb begin
      redirect = flush_trap | flush_branch | flush_jal;
      if (flush_trap) begin
         target = trap_target;
      end else if (flush_branch) begin
         target = branch_target;
      end else begin
         target = jal_target;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with a one-entry output slot and redirect handling.
// Optional misaligned-target trapping is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush_trap,
   input  logic [31:0] trap_target,
   input  logic        flush_branch,
   input  logic [31:0] branch_target,
   input  logic        flush_jal,
   input  logic [31:0] jal_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic        fetch_misalign
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic [31:0]  instr_q, instr_d;
   logic         req_q, req_d;
   logic         valid_q, valid_d;
   logic         misalign_q, misalign_d;

   logic         redirect;
   logic         consumed;
   logic         target_bad;
   logic [31:0]  raw_target;
   logic [31:0]  target;

   fetch_redirect_sel u_redirect_sel (
      .flush_trap    (flush_trap),
      .trap_target   (trap_target),
      .flush_branch  (flush_branch),
      .branch_target (branch_target),
      .flush_jal     (flush_jal),
      .jal_target    (jal_target),
      .redirect      (redirect),
      .target        (raw_target)
   );

   assign consumed = valid_q && !stall;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target     = raw_target;
   assign target_bad = redirect && (raw_target[1:0] != 2'b00);
`else
   assign target     = raw_target & 32'hFFFF_FFFC;
   assign target_bad = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      req_d      = 1'b0;
      valid_d    = valid_q;
      pc_out_d   = pc_out_q;
      instr_d    = instr_q;
      misalign_d = misalign_q;

      if (consumed) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end

      if (redirect) begin
         pc_d       = target;
         valid_d    = 1'b0;
         instr_d    = NOP_INSTR;
         misalign_d = target_bad;
         if (target_bad) begin
            pc_out_d = target;
         end
         // An outstanding request must still drain; only a same-cycle response ends it.
         case (state_q)
            FS_WAIT, FS_WAIT_KILL: state_d = imem_rvalid ? FS_IDLE : FS_WAIT_KILL;
            default:               state_d = FS_IDLE;
         endcase
      end else begin
         case (state_q)
            FS_IDLE: begin
               if ((!valid_q || consumed) && !misalign_q) begin
                  req_d   = 1'b1;
                  addr_d  = pc_q;
                  state_d = FS_WAIT;
               end
            end
            FS_WAIT: begin
               if (imem_rvalid) begin
                  valid_d  = 1'b1;
                  pc_out_d = addr_q;
                  instr_d  = imem_rdata;
                  pc_d     = addr_q + 32'd4;
                  state_d  = FS_IDLE;
               end
            end
            FS_WAIT_KILL: begin
               if (imem_rvalid) begin
                  state_d = FS_IDLE;
               end
            end
            default: state_d = FS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FS_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= 32'h0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         pc_out_q   <= 32'h0;
         instr_q    <= NOP_INSTR;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         valid_q    <= valid_d;
         pc_out_q   <= pc_out_d;
         instr_q    <= instr_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req       = req_q;
   assign imem_addr      = addr_q;
   assign fetch_valid    = valid_q;
   assign pc_out         = pc_out_q;
   assign instr_out      = instr_q;
   assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against an in-order fetch model.
module tb_fetch_unit;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] RPC  = 32'h0000_0100;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush_trap, flush_branch, flush_jal;
   logic [31:0] trap_target, branch_target, jal_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        fetch_misalign;

   int          total;
   int          bad;
   int          mem_lat;
   int          mem_cnt;
   logic [31:0] mem_addr;
   logic [31:0] salt;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush_trap     (flush_trap),
      .trap_target    (trap_target),
      .flush_branch   (flush_branch),
      .branch_target  (branch_target),
      .flush_jal      (flush_jal),
      .jal_target     (jal_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .fetch_valid    (fetch_valid),
      .pc_out         (pc_out),
      .instr_out      (instr_out),
      .fetch_misalign (fetch_misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   // Memory model: answers each request after mem_lat cycles; cleared by reset.
   initial begin
      mem_cnt     = 0;
      mem_addr    = 32'h0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (!reset) begin
            mem_cnt = 0;
         end else begin
            if (mem_cnt > 0) begin
               mem_cnt = mem_cnt - 1;
               if (mem_cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = mem_word(mem_addr);
               end
            end
            if (imem_req) begin
               mem_cnt  = mem_lat;
               mem_addr = imem_addr;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall         = 1'b0;
      flush_trap    = 1'b0;
      flush_branch  = 1'b0;
      flush_jal     = 1'b0;
      trap_target   = 32'h0;
      branch_target = 32'h0;
      jal_target    = 32'h0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic wait_req(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (imem_req) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (fetch_valid) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      logic [98:0] got, exp;
      reset = 1'b1;
      clear_inputs();
      mem_lat = 1;
      #2 reset = 1'b0;
      step();
      got = {imem_req, imem_addr, fetch_valid, pc_out, instr_out, fetch_misalign};
      exp = {1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL reset_values: got %h expected %h", got, exp);
      end
   endtask

   task automatic test_sequence();
      int n;
      logic [31:0] a;
      mem_lat = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a = RPC + 32'(4 * i);
         wait_req(n);
         total++;
         if (n < 1 || imem_addr !== a) begin
            bad++;
            $display("FAIL seq_req%0d: got addr %h (n=%0d) expected %h", i, imem_addr, n, a);
         end
         if (i > 0) begin
            total++;
            if (fetch_valid !== 1'b0 || instr_out !== NOP) begin
               bad++;
               $display("FAIL seq_slot_cleared%0d: got valid %b instr %h expected 0 %h", i, fetch_valid, instr_out, NOP);
            end
         end
         wait_valid(n);
         total++;
         if (n !== 2 || pc_out !== a || instr_out !== mem_word(a)) begin
            bad++;
            $display("FAIL seq_slot%0d: got n=%0d pc %h instr %h expected n=2 pc %h instr %h", i, n, pc_out, instr_out, a, mem_word(a));
         end
      end
   endtask

   task automatic test_stall();
      int n;
      int reqs;
      mem_lat = 1;
      do_reset();
      wait_req(n);
      wait_valid(n);
      wait_req(n);
      total++;
      if (n < 1 || imem_addr !== RPC + 32'h4) begin
         bad++;
         $display("FAIL stall_req104: got %h expected %h", imem_addr, RPC + 32'h4);
      end
      stall = 1'b1;
      wait_valid(n);
      reqs = 0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (fetch_valid !== 1'b1 || pc_out !== RPC + 32'h4 || instr_out !== mem_word(RPC + 32'h4)) begin
            bad++;
            $display("FAIL stall_hold%0d: got valid %b pc %h expected 1 %h", i, fetch_valid, pc_out, RPC + 32'h4);
         end
         if (imem_req) reqs++;
         step();
      end
      total++;
      if (reqs !== 0) begin
         bad++;
         $display("FAIL stall_no_req: got %0d requests expected 0", reqs);
      end
      stall = 1'b0;
      step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== RPC + 32'h8) begin
         bad++;
         $display("FAIL stall_release_req: got req %b addr %h expected 1 %h", imem_req, imem_addr, RPC + 32'h8);
      end
   endtask

   task automatic test_branch_flush();
      int n;
      bit seen_valid;
      bit got_req;
      mem_lat = 3;
      do_reset();
      wait_req(n);
      step();
      flush_branch  = 1'b1;
      branch_target = 32'h200;
      step();
      flush_branch = 1'b0;
      total++;
      if (fetch_valid !== 1'b0 || instr_out !== NOP) begin
         bad++;
         $display("FAIL branch_slot_clear: got valid %b instr %h expected 0 %h", fetch_valid, instr_out, NOP);
      end
      seen_valid = 1'b0;
      got_req    = 1'b0;
      for (int i = 0; i < 20 && !got_req; i++) begin
         step();
         if (fetch_valid) seen_valid = 1'b1;
         if (imem_req) got_req = 1'b1;
      end
      total++;
      if (seen_valid || !got_req || imem_addr !== 32'h200) begin
         bad++;
         $display("FAIL branch_redirect: got stale %b req %b addr %h expected 0 1 00000200", seen_valid, got_req, imem_addr);
      end
      wait_valid(n);
      total++;
      if (n < 1 || pc_out !== 32'h200 || instr_out !== mem_word(32'h200)) begin
         bad++;
         $display("FAIL branch_fetch: got pc %h instr %h expected 00000200 %h", pc_out, instr_out, mem_word(32'h200));
      end
   endtask

   task automatic test_same_cycle_flush();
      int n;
      mem_lat = 1;
      do_reset();
      wait_req(n);
      step();
      flush_trap  = 1'b1;
      trap_target = 32'h80;
      flush_jal   = 1'b1;
      jal_target  = 32'h300;
      step();
      clear_inputs();
      total++;
      if (fetch_valid !== 1'b0 || instr_out !== NOP) begin
         bad++;
         $display("FAIL samecyc_drop: got valid %b instr %h expected 0 %h", fetch_valid, instr_out, NOP);
      end
      wait_req(n);
      total++;
      if (n < 1 || imem_addr !== 32'h80) begin
         bad++;
         $display("FAIL samecyc_req: got %h (n=%0d) expected 00000080", imem_addr, n);
      end
      wait_valid(n);
      total++;
      if (n < 1 || pc_out !== 32'h80) begin
         bad++;
         $display("FAIL samecyc_fetch: got pc %h expected 00000080", pc_out);
      end
   endtask

   task automatic test_misalign();
      int n;
      int reqs;
      mem_lat = 1;
      do_reset();
      wait_req(n);
      flush_jal  = 1'b1;
      jal_target = 32'h302;
      step();
      clear_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
      reqs = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (imem_req) reqs++;
      end
      total++;
      if (fetch_misalign !== 1'b1 || pc_out !== 32'h302 || fetch_valid !== 1'b0 || reqs !== 0) begin
         bad++;
         $display("FAIL misalign_hold: got flag %b pc %h valid %b reqs %0d expected 1 00000302 0 0", fetch_misalign, pc_out, fetch_valid, reqs);
      end
      flush_trap  = 1'b1;
      trap_target = 32'h80;
      step();
      clear_inputs();
      total++;
      if (fetch_misalign !== 1'b0) begin
         bad++;
         $display("FAIL misalign_clear: got %b expected 0", fetch_misalign);
      end
      wait_req(n);
      total++;
      if (n < 1 || imem_addr !== 32'h80) begin
         bad++;
         $display("FAIL misalign_req: got %h expected 00000080", imem_addr);
      end
`else
      reqs = 0;
      wait_req(n);
      total++;
      if (n < 1 || imem_addr !== 32'h300 || fetch_misalign !== 1'b0) begin
         bad++;
         $display("FAIL align_force: got addr %h flag %b expected 00000300 0", imem_addr, fetch_misalign);
      end
      total++;
      if (reqs !== 0 || fetch_misalign !== 1'b0) begin
         bad++;
         $display("FAIL align_flag: got %b expected 0", fetch_misalign);
      end
`endif
   endtask

   task automatic test_reset_mid_request();
      int n;
      logic [98:0] got, exp;
      bit seen_valid;
      bit got_req;
      mem_lat = 3;
      do_reset();
      wait_req(n);
      step();
      #2 reset = 1'b0;
      #1;
      got = {imem_req, imem_addr, fetch_valid, pc_out, instr_out, fetch_misalign};
      exp = {1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL reset_async: got %h expected %h", got, exp);
      end
      step();
      step();
      reset = 1'b1;
      seen_valid = 1'b0;
      got_req    = 1'b0;
      for (int i = 0; i < 10 && !got_req; i++) begin
         step();
         if (fetch_valid) seen_valid = 1'b1;
         if (imem_req) got_req = 1'b1;
      end
      total++;
      if (seen_valid || !got_req || imem_addr !== RPC) begin
         bad++;
         $display("FAIL reset_restart: got stale %b req %b addr %h expected 0 1 %h", seen_valid, got_req, imem_addr, RPC);
      end
      wait_valid(n);
      total++;
      if (n !== 4 || pc_out !== RPC) begin
         bad++;
         $display("FAIL reset_first_fetch: got n=%0d pc %h expected n=4 pc %h", n, pc_out, RPC);
      end
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           t = $urandom & 32'h0000_FFFF;
`ifdef FETCH_MISALIGN_TRAP_EN
      t = t & 32'hFFFF_FFFC;
`endif
      return t;
   endfunction

   // Model: after a redirect to T the slot must deliver T, T+4, ... in order, each with mem_word(pc).
   task automatic test_random();
      logic [31:0] exp_pc, prev_pc, prev_instr, req_addr, win;
      bit hold_prev, redir_prev, outstanding;
      mem_lat = 2;
      do_reset();
      exp_pc      = RPC;
      hold_prev   = 1'b0;
      redir_prev  = 1'b0;
      outstanding = 1'b0;
      prev_pc     = 32'h0;
      prev_instr  = 32'h0;
      req_addr    = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (imem_req) begin
            total++;
            if (outstanding) begin
               bad++;
               $display("FAIL rnd_two_outstanding: cycle %0d got second req at %h expected none", c, imem_addr);
            end
            outstanding = 1'b1;
            req_addr    = imem_addr;
         end else if (outstanding) begin
            total++;
            if (imem_addr !== req_addr) begin
               bad++;
               $display("FAIL rnd_addr_stable: cycle %0d got %h expected %h", c, imem_addr, req_addr);
            end
            if (imem_rvalid) outstanding = 1'b0;
         end
         if (redir_prev) begin
            total++;
            if (fetch_valid !== 1'b0 || instr_out !== NOP) begin
               bad++;
               $display("FAIL rnd_redirect_clear: cycle %0d got valid %b instr %h expected 0 %h", c, fetch_valid, instr_out, NOP);
            end
         end else if (hold_prev) begin
            total++;
            if (fetch_valid !== 1'b1 || pc_out !== prev_pc || instr_out !== prev_instr) begin
               bad++;
               $display("FAIL rnd_stall_hold: cycle %0d got %b %h %h expected 1 %h %h", c, fetch_valid, pc_out, instr_out, prev_pc, prev_instr);
            end
         end else if (fetch_valid) begin
            total++;
            if (pc_out !== exp_pc || instr_out !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL rnd_delivery: cycle %0d got pc %h instr %h expected %h %h", c, pc_out, instr_out, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end else begin
            total++;
            if (instr_out !== NOP || fetch_misalign !== 1'b0) begin
               bad++;
               $display("FAIL rnd_empty_slot: cycle %0d got instr %h flag %b expected %h 0", c, instr_out, fetch_misalign, NOP);
            end
         end
         stall         = ($urandom_range(0, 2) == 0);
         flush_trap    = ($urandom_range(0, 19) == 0);
         flush_branch  = ($urandom_range(0, 19) == 0);
         flush_jal     = ($urandom_range(0, 19) == 0);
         trap_target   = rand_target();
         branch_target = rand_target();
         jal_target    = rand_target();
         if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(1, 4);
         redir_prev = flush_trap || flush_branch || flush_jal;
         if (redir_prev) begin
            if (flush_trap)        win = trap_target;
            else if (flush_branch) win = branch_target;
            else                   win = jal_target;
            exp_pc = win & 32'hFFFF_FFFC;
         end
         hold_prev  = fetch_valid && stall && !redir_prev;
         prev_pc    = pc_out;
         prev_instr = instr_out;
      end
      clear_inputs();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      salt  = $urandom;
      test_reset();
      test_sequence();
      test_stall();
      test_branch_flush();
      test_same_cycle_flush();
      test_misalign();
      test_reset_mid_request();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
